// File: rtl/uop_gate_arbiter.sv
// Round-robin arbiter sharing one AND/NAND gate among N requesters: IDLE -> EXEC -> RESP, one op per 3 cycles.
// Define UOP_GATE_ARB_STATS_EN to add saturating per-requester grant counters on gnt_cnt.
module uop_gate_arbiter #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       op,
    input  logic [N-1:0]       x,
    input  logic [N-1:0]       y,
    output logic [N-1:0]       gnt,
    output logic               z,
    output logic               done,
`ifdef UOP_GATE_ARB_STATS_EN
    output logic [N*CNT_W-1:0] gnt_cnt,
`endif
    output logic               busy
);

    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_q, win_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          op_q, op_d;
    logic          x_q, x_d;
    logic          y_q, y_d;
    logic          z_q, z_d;
    logic          done_q, done_d;

    // First set bit at or above p, wrapping past N-1 back to 0.
    function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] sel;
        logic [PW-1:0] idx;
        logic          found;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(p) + k) % N);
            if (!found && r[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return sel;
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    win_d        = rr_pick(req, ptr_q);
                    gnt_d        = '0;
                    gnt_d[win_d] = 1'b1;
                    op_d         = op[win_d];
                    x_d          = x[win_d];
                    y_d          = y[win_d];
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                z_d     = op_q ? ~(x_q & y_q) : (x_q & y_q);
                done_d  = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                gnt_d   = '0;
                ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            op_q    <= 1'b0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign gnt  = gnt_q;
    assign z    = z_q;
    assign done = done_q;
    assign busy = (state_q != S_IDLE);

`ifdef UOP_GATE_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (state_q == S_RESP && cnt_q[win_q] != '1) begin
            cnt_q[win_q] <= cnt_q[win_q] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_cnt_out
        assign gnt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_uop_gate_arbiter.sv
// Self-checking bench for uop_gate_arbiter: transaction-level reference model plus directed literal checks.
module tb_uop_gate_arbiter;

    localparam int N     = 4;
    localparam int CNT_W = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req, op, x, y;
    logic [N-1:0] gnt;
    logic         z, done, busy;
`ifdef UOP_GATE_ARB_STATS_EN
    logic [N*CNT_W-1:0] gnt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: one in-flight transaction, its age since grant, and round-robin pointer.
    bit m_act;
    int m_age;
    int m_w;
    bit m_r;
    bit m_z;
    int m_ptr;
    int m_cnt [N];
    int order_q [$];

    uop_gate_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .op      (op),
        .x       (x),
        .y       (y),
        .gnt     (gnt),
        .z       (z),
        .done    (done),
`ifdef UOP_GATE_ARB_STATS_EN
        .gnt_cnt (gnt_cnt),
`endif
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, then compare at negedge.
    task automatic step(input bit rst, input logic [N-1:0] r, input logic [N-1:0] o,
                        input logic [N-1:0] xx, input logic [N-1:0] yy);
        int gi;
        reset = rst; req = r; op = o; x = xx; y = yy;
        @(posedge clk);
        if (rst) begin
            m_act = 0; m_ptr = 0; m_z = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (m_act && m_age == 1) begin
            m_age = 2;
            m_z   = m_r;
        end else if (m_act) begin
            m_act = 0;
            m_ptr = (m_w + 1) % N;
            if (m_cnt[m_w] < (1 << CNT_W) - 1) m_cnt[m_w]++;
        end else if (r != '0) begin
            m_w   = pick(r, m_ptr);
            m_r   = o[m_w] ? !(xx[m_w] && yy[m_w]) : (xx[m_w] && yy[m_w]);
            m_act = 1;
            m_age = 1;
        end
        @(negedge clk);
        chk("gnt",  32'(gnt),  m_act ? (32'(1) << m_w) : 32'(0));
        chk("done", 32'(done), 32'(m_act && m_age == 2));
        chk("busy", 32'(busy), 32'(m_act));
        chk("z",    32'(z),    32'(m_z));
`ifdef UOP_GATE_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("gnt_cnt", 32'(gnt_cnt[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
`endif
        if (done === 1'b1) begin
            gi = -1;
            for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
            order_q.push_back(gi);
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; op = '0; x = '0; y = '0;

        // Basic latency from reset
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("rst_gnt",  32'(gnt),  32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_z",    32'(z),    32'h0);
        step(0, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
        chk("c1_gnt",  32'(gnt),  32'h1);
        chk("c1_done", 32'(done), 32'h0);
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("c2_done", 32'(done), 32'h1);
        chk("c2_z",    32'(z),    32'h1);
        chk("c2_gnt",  32'(gnt),  32'h1);
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("c3_gnt",  32'(gnt),  32'h0);
        chk("c3_busy", 32'(busy), 32'h0);

        // NAND on requester 2; operand changes after latching must not matter
        step(0, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
        step(0, 4'b0100, 4'b0000, 4'b0000, 4'b1111);
        chk("nand10_done", 32'(done), 32'h1);
        chk("nand10_z",    32'(z),    32'h1);
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(0, 4'b0100, 4'b0100, 4'b0100, 4'b0100);
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("nand11_z", 32'(z), 32'h0);
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("z_hold", 32'(z), 32'h0);

        // All requesting: round-robin order 0,1,2,3,0,1,2,3
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        order_q.delete();
        for (int i = 0; i < 24; i++) begin
            step(0, 4'b1111, 4'($urandom), 4'($urandom), 4'($urandom));
        end
        chk("rr_count", 32'(order_q.size()), 32'd8);
        for (int i = 0; i < order_q.size() && i < 8; i++) begin
            chk("rr_order", 32'(order_q[i]), 32'(i % 4));
        end

        // Pointer wrap after winner 3
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(0, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
        chk("wrap_gnt", 32'(gnt), 32'h1);
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Reset during EXEC aborts without done and without moving the pointer
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(0, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("abort_gnt",  32'(gnt),  32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        step(0, 4'b1010, 4'b0000, 4'b0000, 4'b0000);
        chk("abort_next_gnt", 32'(gnt), 32'h2);
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

`ifdef UOP_GATE_ARB_STATS_EN
        // Counter saturation
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            step(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
            step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
            step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        chk("sat_cnt0", 32'(gnt_cnt[0 +: CNT_W]), 32'd3);
        for (int i = 1; i < N; i++) chk("sat_cnt_other", 32'(gnt_cnt[i*CNT_W +: CNT_W]), 32'd0);
`endif

        // Randomized traffic with occasional resets
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 800; i++) begin
            logic [N-1:0] rr;
            rr = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            step($urandom_range(0, 39) == 0, rr, 4'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
